// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction control unit: FSM states and opcodes.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        EXEC   = 2'd3
    } state_t;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_JNZ = 2'b11;

endpackage

// File: rtl/alu_addsub_8.sv
// Combinational 8-bit adder/subtractor; c is carry-out on add and borrow on subtract.
module alu_addsub_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] y,
    output logic       c
);

    logic [8:0] w_result;

    // A 9-bit unsigned subtract sets bit 8 exactly when a < b.
    assign w_result = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    assign y        = w_result[7:0];
    assign c        = w_result[8];

endmodule

// File: rtl/instr_ctrl_unit.sv
// Multi-cycle fetch/decode/execute control stage driving an external 10-bit instruction register.
module instr_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter logic [7:0]  ACC_RST = 8'h00
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            instr_valid,
    output logic            ir_load,
    input  logic [1:0]      opcode,
    input  logic [7:0]      operand,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      acc,
    output logic            carry,
    output logic            zero,
    output logic            busy,
    output logic            done
);

    state_t          r_state;
    state_t          w_nextState;
    logic            w_irLoad;
    logic [1:0]      r_op;
    logic [7:0]      r_operand;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pcInc;
    logic [7:0]      r_acc;
    logic            r_carry;
    logic            r_zero;
    logic            r_done;
    logic            w_aluSub;
    logic [7:0]      w_aluY;
    logic            w_aluC;

    assign w_aluSub = (r_op == OP_SUB);
    assign w_pcInc  = r_pc + PC_W'(1);

    alu_addsub_8 u_alu (
        .a   (r_acc),
        .b   (r_operand),
        .sub (w_aluSub),
        .y   (w_aluY),
        .c   (w_aluC)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The load-select is only raised while fetching with run still held, so one load per instruction.
    always_comb begin
        w_nextState = r_state;
        w_irLoad    = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                if (!run) begin
                    w_nextState = IDLE;
                end else if (instr_valid) begin
                    w_irLoad    = 1'b1;
                    w_nextState = DECODE;
                end
            end
            DECODE: begin
                w_nextState = EXEC;
            end
            EXEC: begin
                w_nextState = run ? FETCH : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_LDI;
            r_operand <= 8'h00;
        end else if (r_state == DECODE) begin
            r_op      <= opcode;
            r_operand <= operand;
        end
    end

    // Architectural state only changes on the edge leaving EXEC; a reset on that edge discards the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_acc   <= ACC_RST;
            r_carry <= 1'b0;
            r_zero  <= (ACC_RST == 8'h00);
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == EXEC);
            if (r_state == EXEC) begin
                case (r_op)
                    OP_LDI: begin
                        r_acc  <= r_operand;
                        r_zero <= (r_operand == 8'h00);
                        r_pc   <= w_pcInc;
                    end
                    OP_ADD, OP_SUB: begin
                        r_acc   <= w_aluY;
                        r_carry <= w_aluC;
                        r_zero  <= (w_aluY == 8'h00);
                        r_pc    <= w_pcInc;
                    end
                    default: begin
                        r_pc <= r_zero ? w_pcInc : r_operand[PC_W-1:0];
                    end
                endcase
            end
        end
    end

    assign ir_load = w_irLoad;
    assign pc      = r_pc;
    assign acc     = r_acc;
    assign carry   = r_carry;
    assign zero    = r_zero;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_instr_ctrl_unit.sv
// Bench for instr_ctrl_unit: models the instruction register and memory, scoreboards every retirement.
module tb_instr_ctrl_unit;
    import ctrl_pkg::*;

    typedef struct {
        logic [7:0] addr;
        logic [1:0] op;
        logic [7:0] opnd;
        logic [7:0] eAcc;
        logic       eC;
        logic       eZ;
        logic [7:0] ePc;
    } vec_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic [7:0] pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, run, validEn, irLoad;
    logic       instrValid;
    logic [7:0] stopAddr;
    logic [9:0] irWord;
    logic [7:0] pc, acc;
    logic       carry, zero, busy, done;

    logic       resetB, runB, irLoadB;
    logic [9:0] irWordB;
    logic [2:0] pcB;
    logic [7:0] accB;
    logic       carryB, zeroB, busyB, doneB;

    logic [9:0] mem [256];
    logic [9:0] memB [8];
    vec_t       vecs [12];
    exp_t       tableExp [256];
    exp_t       sbq [$];

    int nCompared = 0;
    int nMismatched = 0;
    int cyc = 0;
    int doneCount = 0;
    int doneCountB = 0;
    int subRetires = 0;
    int firstDoneCyc = 0;
    int secondDoneCyc = 0;
    logic useTable;

    logic [7:0] mAcc, mPc;
    logic       mC, mZ;
    logic [9:0] loadWord, loadWordB;
    logic       loadPend, loadPendB;
    exp_t       curExp, popExp;

    assign instrValid = validEn && (pc != stopAddr);

    instr_ctrl_unit #(.PC_W(8), .ACC_RST(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr_valid (instrValid),
        .ir_load     (irLoad),
        .opcode      (irWord[9:8]),
        .operand     (irWord[7:0]),
        .pc          (pc),
        .acc         (acc),
        .carry       (carry),
        .zero        (zero),
        .busy        (busy),
        .done        (done)
    );

    instr_ctrl_unit #(.PC_W(3), .ACC_RST(8'h5A)) dutB (
        .clk         (clk),
        .reset       (resetB),
        .run         (runB),
        .instr_valid (1'b1),
        .ir_load     (irLoadB),
        .opcode      (irWordB[9:8]),
        .operand     (irWordB[7:0]),
        .pc          (pcB),
        .acc         (accB),
        .carry       (carryB),
        .zero        (zeroB),
        .busy        (busyB),
        .done        (doneB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic r, input logic v);
        reset   = rst;
        run     = r;
        validEn = v;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDone(input int target, input int budget);
        for (int i = 0; i < budget && doneCount < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (doneCount < target) checkOutput("doneTimeout", doneCount, target);
    endtask

    // Instruction registers: the load decision is sampled mid-cycle and applied on the next edge.
    always @(posedge clk) begin
        cyc++;
        if (loadPend) irWord <= loadWord;
        if (loadPendB) irWordB <= loadWordB;
    end

    always @(negedge clk) begin
        loadPend  = irLoad;
        loadWord  = mem[pc];
        loadPendB = irLoadB;
        loadWordB = memB[pcB];

        if (done) begin
            doneCount++;
            if (doneCount == 1) firstDoneCyc = cyc;
            if (doneCount == 2) secondDoneCyc = cyc;
            if (sbq.size() == 0) begin
                checkOutput("retireUnexpected", 32'd1, 32'd0);
            end else begin
                popExp = sbq.pop_front();
                if (popExp.op == OP_SUB) subRetires++;
                checkOutput("retireAccCZPc", {acc, carry, zero, pc},
                            {popExp.acc, popExp.c, popExp.z, popExp.pc});
            end
        end

        if (reset) begin
            sbq.delete();
            mAcc = 8'h00;
            mC   = 1'b0;
            mZ   = 1'b1;
            mPc  = 8'h00;
        end else if (irLoad) begin
            checkOutput("fetchPc", pc, mPc);
            case (loadWord[9:8])
                OP_LDI: mAcc = loadWord[7:0];
                OP_ADD: {mC, mAcc} = {1'b0, mAcc} + {1'b0, loadWord[7:0]};
                OP_SUB: begin
                    mC   = (mAcc < loadWord[7:0]);
                    mAcc = mAcc - loadWord[7:0];
                end
                default: ;
            endcase
            if (loadWord[9:8] == OP_JNZ) begin
                mPc = mZ ? mPc + 8'd1 : loadWord[7:0];
            end else begin
                mZ  = (mAcc == 8'h00);
                mPc = mPc + 8'd1;
            end
            if (useTable) curExp = tableExp[pc];
            else curExp = '{loadWord[9:8], mAcc, mC, mZ, mPc};
            sbq.push_back(curExp);
        end

        if (doneB) begin
            doneCountB++;
            if (doneCountB == 7) checkOutput("narrowPcAt7", {5'd0, pcB, accB}, {8'd7, 8'h06});
            if (doneCountB == 8) checkOutput("narrowPcWrap", {5'd0, pcB, accB}, {8'd0, 8'h07});
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL globalTimeout: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic seen;

        vecs[0]  = '{8'd0,  OP_LDI, 8'hF0, 8'hF0, 1'b0, 1'b0, 8'd1};
        vecs[1]  = '{8'd1,  OP_ADD, 8'h20, 8'h10, 1'b1, 1'b0, 8'd2};
        vecs[2]  = '{8'd2,  OP_LDI, 8'h05, 8'h05, 1'b1, 1'b0, 8'd3};
        vecs[3]  = '{8'd3,  OP_SUB, 8'h05, 8'h00, 1'b0, 1'b1, 8'd4};
        vecs[4]  = '{8'd4,  OP_SUB, 8'h01, 8'hFF, 1'b1, 1'b0, 8'd5};
        vecs[5]  = '{8'd5,  OP_JNZ, 8'h07, 8'hFF, 1'b1, 1'b0, 8'd7};
        vecs[6]  = '{8'd6,  OP_LDI, 8'h55, 8'h55, 1'b1, 1'b0, 8'd7};
        vecs[7]  = '{8'd7,  OP_LDI, 8'h00, 8'h00, 1'b1, 1'b1, 8'd8};
        vecs[8]  = '{8'd8,  OP_JNZ, 8'h00, 8'h00, 1'b1, 1'b1, 8'd9};
        vecs[9]  = '{8'd9,  OP_ADD, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'd10};
        vecs[10] = '{8'd10, OP_ADD, 8'h01, 8'h00, 1'b1, 1'b1, 8'd11};
        vecs[11] = '{8'd11, OP_LDI, 8'h3C, 8'h3C, 1'b1, 1'b0, 8'd12};

        for (int i = 0; i < 256; i++) begin
            mem[i]      = {OP_LDI, 8'h00};
            tableExp[i] = '{OP_LDI, 8'h00, 1'b0, 1'b0, 8'h00};
        end
        for (int i = 0; i < 12; i++) begin
            mem[vecs[i].addr]      = {vecs[i].op, vecs[i].opnd};
            tableExp[vecs[i].addr] = '{vecs[i].op, vecs[i].eAcc, vecs[i].eC, vecs[i].eZ, vecs[i].ePc};
        end
        for (int i = 0; i < 8; i++) memB[i] = {OP_LDI, 8'(i)};

        irWord   = 10'd0;
        irWordB  = 10'd0;
        useTable = 1'b1;
        stopAddr = 8'd11;
        resetB   = 1'b1;
        runB     = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(2);

        @(negedge clk);
        checkOutput("rstPc", pc, 8'd0);
        checkOutput("rstAcc", acc, 8'h00);
        checkOutput("rstFlagsZC", {zero, carry}, 2'b10);
        checkOutput("rstBusyDoneLoad", {busy, done, irLoad}, 3'b000);
        checkOutput("rstNarrowAccZero", {accB, zeroB, pcB}, {8'h5A, 1'b0, 3'd0});

        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        resetB = 1'b0;
        runB   = 1'b1;
        tick(1);
        @(negedge clk);
        checkOutput("cycle1LoadBusyPc", {irLoad, busy, pc}, {1'b1, 1'b1, 8'd0});

        waitDone(10, 200);
        checkOutput("retireInterval", secondDoneCyc - firstDoneCyc, 32'd3);

        // Fetch is parked at address 11 while the source reports not-valid.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stallLoadBusyPc", {irLoad, busy, pc}, {1'b0, 1'b1, 8'd11});
        end
        @(posedge clk);
        #1;
        stopAddr = 8'd12;
        waitDone(11, 50);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        @(negedge clk);
        checkOutput("runDropIdle", {busy, irLoad, pc}, {1'b0, 1'b0, 8'd12});

        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        useTable = 1'b0;
        mem[0]   = {OP_LDI, 8'h03};
        mem[1]   = {OP_SUB, 8'h01};
        mem[2]   = {OP_JNZ, 8'h01};
        mem[3]   = {OP_LDI, 8'hEE};
        stopAddr = 8'd3;
        tick(2);
        doneCount  = 0;
        subRetires = 0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitDone(7, 200);
        checkOutput("loopEndPcAccZ", {pc, acc, zero}, {8'd3, 8'h00, 1'b1});
        checkOutput("loopSubRetires", subRetires, 32'd3);

        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        mem[0]   = {OP_LDI, 8'h77};
        stopAddr = 8'd1;
        tick(2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (irLoad) seen = 1'b1;
        end
        checkOutput("abortFetchSeen", seen, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("abortState", {acc, pc, carry, zero, busy, done}, {8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        checkOutput("abortNoDone", done, 1'b0);

        checkOutput("narrowRetired", (doneCountB >= 8), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
